// File: rtl/ram_load_sequencer_pkg.sv
// ram_load_sequencer_pkg
//   Shared definitions for the RAM load/dump sequencer: default bus and
//   address widths, memory depth and the sequencer state encoding.
//   No ports (package).
package ram_load_sequencer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;

  // 3-bit state encoding; the enum literals double as the ST_* constants.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_P_ADDR  = 3'd1,
    ST_P_WRITE = 3'd2,
    ST_D_ADDR  = 3'd3,
    ST_D_READ  = 3'd4,
    ST_D_OUT   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // The sequencer owns the RAM in every state except the two resting ones.
  function automatic logic is_busy(input state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/ram_load_sequencer.sv
// ram_load_sequencer
//   Owns the shared bus, the MAR load strobe and the RAM strobes.
//   RUN mode (prog_mode=0, not busy): CPU strobes pass straight through.
//   PROGRAM mode: bytes from the load stream are written to RAM at
//   consecutive addresses (MAR load cycle, then RAM write cycle), and a
//   start_dump pulse streams all RAM words out from address 0.
//
//   Handshakes: a stream word transfers on a rising clk edge where both
//   valid and ready are 1. The producer must hold valid and data steady
//   until that edge; ready may be asserted independently of valid.
//   (in_valid/in_ready: load stream in; out_valid/out_ready: dump stream out.)
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   prog_mode                     1 = PROGRAM/dump, 0 = RUN
//   cpu_mar_load/ram_enable/ram_write   CPU strobes for RUN passthrough
//   in_valid, in_data, in_ready   load stream
//   start_dump                    one-cycle pulse: dump all words from 0
//   out_valid, out_data, out_ready dump stream
//   bus_in                        current shared-bus value
//   bus_out, bus_drive_en         value/enable this block drives on the bus
//   mar_load, ram_enable, ram_write  strobes to MAR and RAM
//   busy, done                    status
//   state_dbg                     current FSM state, for observation
module ram_load_sequencer
  import ram_load_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_mode,
  input  logic                  cpu_mar_load,
  input  logic                  cpu_ram_enable,
  input  logic                  cpu_ram_write,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  start_dump,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_drive_en,
  output logic                  mar_load,
  output logic                  ram_enable,
  output logic                  ram_write,
  output logic                  busy,
  output logic                  done,
  output state_t                state_dbg
);

  localparam int PAD = DATA_WIDTH - ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   ptr_inc;
  logic [DATA_WIDTH-1:0]   hold;
  logic [DATA_WIDTH-1:0]   ptr_word;
  logic [DATA_WIDTH-1:0]   inc_word;

  // Registered FSM strobes; set on the transition into the state that owns them.
  logic                    drive_q;
  logic                    mar_q;
  logic                    write_q;
  logic                    renable_q;
  logic [DATA_WIDTH-1:0]   bus_q;

  assign ptr_inc  = ptr + 1'b1;
  assign ptr_word = {{PAD{1'b0}}, ptr};
  assign inc_word = {{PAD{1'b0}}, ptr_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold      <= '0;
      drive_q   <= 1'b0;
      mar_q     <= 1'b0;
      write_q   <= 1'b0;
      renable_q <= 1'b0;
      bus_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      drive_q   <= 1'b0;
      mar_q     <= 1'b0;
      write_q   <= 1'b0;
      renable_q <= 1'b0;
      bus_q     <= '0;
      case (state)
        ST_IDLE: begin
          if (prog_mode) begin
            if (start_dump) begin
              // Dump always restarts at address 0 and beats a pending byte.
              ptr     <= '0;
              state   <= ST_D_ADDR;
              drive_q <= 1'b1;
              mar_q   <= 1'b1;
            end else if (in_valid) begin
              hold    <= in_data;
              state   <= ST_P_ADDR;
              drive_q <= 1'b1;
              mar_q   <= 1'b1;
              bus_q   <= ptr_word;
            end
          end
        end
        ST_P_ADDR: begin
          state   <= ST_P_WRITE;
          drive_q <= 1'b1;
          write_q <= 1'b1;
          bus_q   <= hold;
        end
        ST_P_WRITE: begin
          ptr   <= ptr_inc;
          state <= (ptr == LAST_ADDR) ? ST_DONE : ST_IDLE;
        end
        ST_D_ADDR: begin
          state     <= ST_D_READ;
          renable_q <= 1'b1;
        end
        ST_D_READ: begin
          // RAM is driving the bus this cycle.
          out_data  <= bus_in;
          out_valid <= 1'b1;
          state     <= ST_D_OUT;
        end
        ST_D_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr       <= ptr_inc;
            if (ptr == LAST_ADDR) begin
              state <= ST_DONE;
            end else begin
              state   <= ST_D_ADDR;
              drive_q <= 1'b1;
              mar_q   <= 1'b1;
              bus_q   <= inc_word;
            end
          end
        end
        ST_DONE: begin
          if (prog_mode && start_dump) begin
            ptr     <= '0;
            state   <= ST_D_ADDR;
            drive_q <= 1'b1;
            mar_q   <= 1'b1;
          end else if (!prog_mode || in_valid) begin
            ptr   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = is_busy(state);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  // Strobe arbitration: FSM strobes while busy or in PROGRAM mode, CPU
  // passthrough otherwise. Everything is forced low while reset is held so
  // no strobe survives an abort.
  always_comb begin
    mar_load     = 1'b0;
    ram_enable   = 1'b0;
    ram_write    = 1'b0;
    bus_drive_en = 1'b0;
    bus_out      = '0;
    in_ready     = 1'b0;
    if (rst_n) begin
      bus_drive_en = drive_q;
      bus_out      = bus_q;
      mar_load     = mar_q;
      ram_write    = write_q;
      ram_enable   = renable_q;
      if (!busy && !prog_mode) begin
        mar_load   = cpu_mar_load;
        ram_enable = cpu_ram_enable;
        ram_write  = cpu_ram_write;
      end
      in_ready = (state == ST_IDLE) && prog_mode && !start_dump;
    end
  end

endmodule

// File: tb/tb_ram_load_sequencer.sv
// Bench for ram_load_sequencer: surrounds the DUT with a 16x8 RAM and a
// 4-bit MAR on a resolved shared bus, drives randomized load/dump traffic
// and checks against an array model of RAM contents plus an expected queue.
module tb_ram_load_sequencer;
  import ram_load_sequencer_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NW = 16;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          prog_mode = 1'b0;
  logic          cpu_mar_load = 1'b0, cpu_ram_enable = 1'b0, cpu_ram_write = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          start_dump = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [DW-1:0] bus_out;
  logic          bus_drive_en, mar_load, ram_enable, ram_write, busy, done;
  state_t        state_dbg;
  logic          cpu_bus_en = 1'b0;
  logic [DW-1:0] cpu_bus_val = '0;

  // RAM + MAR on the shared bus
  logic [DW-1:0] mem [NW];
  logic [AW-1:0] mar;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] bus;
  assign ram_q = mem[mar];
  assign bus = bus_drive_en ? bus_out : (ram_enable ? ram_q : (cpu_bus_en ? cpu_bus_val : '0));

  always @(posedge clk) begin
    if (ram_write) mem[mar] <= bus;
    if (mar_load) mar <= bus[AW-1:0];
  end

  int   mar_loads = 0;
  int   ram_writes = 0;
  logic inv_bad = 1'b0;
  always @(posedge clk) begin
    if (mar_load) mar_loads <= mar_loads + 1;
    if (ram_write) ram_writes <= ram_writes + 1;
  end
  always @(negedge clk) if (bus_drive_en && ram_enable) inv_bad <= 1'b1;

  ram_load_sequencer dut (
    .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode),
    .cpu_mar_load(cpu_mar_load), .cpu_ram_enable(cpu_ram_enable), .cpu_ram_write(cpu_ram_write),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start_dump(start_dump), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .bus_in(bus), .bus_out(bus_out), .bus_drive_en(bus_drive_en),
    .mar_load(mar_load), .ram_enable(ram_enable), .ram_write(ram_write),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // scoreboard state
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model_mem [NW];
  logic [DW-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; prog_mode = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
    cpu_mar_load = 1'b1; cpu_ram_enable = 1'b1; cpu_ram_write = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mar_load, ram_enable, ram_write, bus_drive_en} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {mar_load, ram_enable, ram_write, bus_drive_en});
    end
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0) begin
      errors++; $display("FAIL reset_status: got %b expected 0000", {in_ready, out_valid, busy, done});
    end
    checks++;
    if (bus_out !== 8'h00 || out_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got bus_out=%h out_data=%h expected 00", bus_out, out_data);
    end
    cpu_mar_load = 1'b0; cpu_ram_enable = 1'b0; cpu_ram_write = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_full();
    int n, prev, cyc, addr;
    logic acc;
    n = 0; prev = -1; cyc = 0; addr = 0;
    prog_mode = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    while (n < NW && cyc < 200) begin
      @(negedge clk);
      acc = in_ready && in_valid;
      if (acc) begin
        if (prev >= 0) begin
          checks++;
          if (cyc - prev != 3) begin
            errors++; $display("FAIL load_accept_gap: got %0d cycles expected 3", cyc - prev);
          end
        end
        model_mem[addr] = in_data;
        addr = (addr + 1) % NW;
        prev = cyc;
        n++;
      end
      tick();
      cyc++;
      if (acc) begin
        in_data = DW'(255 - n);
        if (n == NW) in_valid = 1'b0;
      end
    end
    checks++;
    if (n != NW) begin
      errors++; in_valid = 1'b0; $display("FAIL load_timeout: got %0d accepts expected %0d", n, NW);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL load_done_plus1: got done=%b busy=%b expected done=0 busy=1", done, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL load_done_plus2: got %b expected 0", done);
    end
    tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL load_done_rise: got done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (mem[i] !== model_mem[i]) begin
        errors++; $display("FAIL load_ram[%0d]: got %h expected %h", i, mem[i], model_mem[i]);
      end
    end
    tick();
  endtask

  task automatic test_dump_full();
    int t;
    logic [DW-1:0] e;
    t = 0;
    exp_q.delete();
    for (int i = 0; i < NW; i++) exp_q.push_back(model_mem[i]);
    out_ready = 1'b1; start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e) begin
          errors++; $display("FAIL dump_word: got %h expected %h", out_data, e);
        end
      end
      tick();
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL dump_timeout: got %0d words left expected 0", exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL dump_done: got done=%b out_valid=%b expected 1/0", done, out_valid);
    end
    tick();
  endtask

  task automatic test_dump_stall();
    int idx, stall, t, mar_base, mar_stall;
    logic [DW-1:0] e;
    idx = 0; stall = 0; t = 0; mar_stall = 0;
    exp_q.delete();
    for (int i = 0; i < NW; i++) exp_q.push_back(model_mem[i]);
    mar_base = mar_loads;
    start_dump = 1'b1; out_ready = 1'b1;
    tick();
    start_dump = 1'b0;
    while (idx < NW && t < 300) begin
      out_ready = (idx == 3 && stall < 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (idx == 3 && !out_ready && (out_valid || stall > 0)) begin
        if (stall == 0) mar_stall = mar_loads;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0] || mar_loads != mar_stall) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h mar_loads=%0d expected 1/%h/%0d",
                   out_valid, out_data, mar_loads, exp_q[0], mar_stall);
        end
        stall++;
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        idx++;
        checks++;
        if (out_data !== e) begin
          errors++; $display("FAIL stall_word: got %h expected %h", out_data, e);
        end
      end
      tick();
      t++;
    end
    out_ready = 1'b1;
    checks++;
    if (idx != NW || stall != 5) begin
      errors++; $display("FAIL stall_progress: got words=%0d stall=%0d expected %0d/5", idx, stall, NW);
    end
    checks++;
    if (mar_loads - mar_base != NW) begin
      errors++; $display("FAIL stall_mar_loads: got %0d expected %0d", mar_loads - mar_base, NW);
    end
  endtask

  task automatic test_run_mode();
    logic m, r, s;
    logic [DW-1:0] b;
    prog_mode = 1'b0;
    tick();  // DONE -> IDLE
    for (int i = 0; i < 8; i++) begin
      m = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      cpu_mar_load = m; cpu_ram_enable = r; cpu_ram_write = 1'b0;
      in_valid = 1'b1; start_dump = s;
      @(negedge clk);
      checks++;
      if ({mar_load, ram_enable, ram_write, bus_drive_en, in_ready, busy} !== {m, r, 4'b0000}) begin
        errors++;
        $display("FAIL run_passthrough: got %b expected %b",
                 {mar_load, ram_enable, ram_write, bus_drive_en, in_ready, busy}, {m, r, 4'b0000});
      end
      tick();
    end
    in_valid = 1'b0; start_dump = 1'b0;
    // point MAR at 0, then write 5A there through the passthrough
    cpu_ram_enable = 1'b0; cpu_mar_load = 1'b1; cpu_bus_en = 1'b1; cpu_bus_val = 8'h00;
    tick();
    cpu_mar_load = 1'b0; cpu_ram_write = 1'b1; cpu_bus_val = 8'h5A;
    @(negedge clk);
    checks++;
    if (ram_write !== 1'b1) begin
      errors++; $display("FAIL run_write_same_cycle: got %b expected 1", ram_write);
    end
    tick();
    cpu_ram_write = 1'b0; cpu_bus_en = 1'b0;
    model_mem[0] = 8'h5A;
    // mode dropped while a load is in flight
    b = DW'($urandom_range(0, 255));
    prog_mode = 1'b1; in_valid = 1'b1; in_data = b;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL busy_accept: got in_ready=%b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0; prog_mode = 1'b0;
    cpu_ram_write = 1'b1; cpu_mar_load = 1'b1; cpu_ram_enable = 1'b1;
    cpu_bus_en = 1'b1; cpu_bus_val = 8'h5A;
    @(negedge clk);
    checks++;
    if ({mar_load, ram_write, ram_enable, bus_drive_en} !== 4'b1001 || bus_out !== 8'h00) begin
      errors++; $display("FAIL busy_p_addr: got %b bus=%h expected 1001 bus=00",
                         {mar_load, ram_write, ram_enable, bus_drive_en}, bus_out);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mar_load, ram_write, ram_enable, bus_drive_en} !== 4'b0101 || bus_out !== b) begin
      errors++; $display("FAIL busy_p_write: got %b bus=%h expected 0101 bus=%h",
                         {mar_load, ram_write, ram_enable, bus_drive_en}, bus_out, b);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({mar_load, ram_write, ram_enable, bus_drive_en, busy} !== 5'b11100 || mem[0] !== b) begin
      errors++; $display("FAIL run_after_p_write: got %b mem0=%h expected 11100 mem0=%h",
                         {mar_load, ram_write, ram_enable, bus_drive_en, busy}, mem[0], b);
    end
    model_mem[0] = b;  // the passthrough write copies RAM[0] onto itself
    tick();
    cpu_ram_write = 1'b0; cpu_mar_load = 1'b0; cpu_ram_enable = 1'b0; cpu_bus_en = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [DW-1:0] b [5];
    logic [DW-1:0] nb;
    int k, t;
    logic acc;
    for (int i = 0; i < 5; i++) b[i] = DW'($urandom_range(0, 255));
    prog_mode = 1'b1;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    k = 0; t = 0; in_data = b[0]; in_valid = 1'b1;
    while (k < 5 && t < 100) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      t++;
      if (acc) begin
        k++;
        if (k < 5) in_data = b[k]; else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (k != 5) begin
      errors++; $display("FAIL abort_load_timeout: got %0d accepts expected 5", k);
    end
    tick();  // now in P_WRITE of word 4
    checks++;
    if (ram_write !== 1'b1) begin
      errors++; $display("FAIL abort_pre_write: got %b expected 1", ram_write);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mar_load, ram_enable, ram_write, bus_drive_en, busy} !== 5'b0) begin
      errors++; $display("FAIL abort_async: got %b expected 00000",
                         {mar_load, ram_enable, ram_write, bus_drive_en, busy});
    end
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) model_mem[i] = b[i];
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem[i] !== model_mem[i]) begin
        errors++; $display("FAIL abort_ram[%0d]: got %h expected %h", i, mem[i], model_mem[i]);
      end
    end
    nb = DW'($urandom_range(0, 255));
    in_data = nb; in_valid = 1'b1; t = 0; acc = 1'b0;
    while (!acc && t < 20) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      t++;
    end
    in_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    model_mem[0] = nb;
    checks++;
    if (mem[0] !== nb || mem[1] !== model_mem[1]) begin
      errors++; $display("FAIL restart_addr0: got mem0=%h mem1=%h expected %h %h", mem[0], mem[1], nb, model_mem[1]);
    end
    tick();
  endtask

  task automatic test_dump_priority();
    int t, wr_base;
    logic [DW-1:0] e;
    t = 0;
    exp_q.delete();
    for (int i = 0; i < NW; i++) exp_q.push_back(model_mem[i]);
    wr_base = ram_writes;
    prog_mode = 1'b1; start_dump = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL prio_in_ready: got %b expected 0", in_ready);
    end
    tick();
    start_dump = 1'b0; in_valid = 1'b0;
    while (exp_q.size() > 0 && t < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e) begin
          errors++; $display("FAIL prio_dump_word: got %h expected %h", out_data, e);
        end
      end
      tick();
      t++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || done !== 1'b1 || ram_writes != wr_base) begin
      errors++; $display("FAIL prio_end: got left=%0d done=%b writes=%0d expected 0/1/0",
                         exp_q.size(), done, ram_writes - wr_base);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d [NW];
    int k, t;
    logic acc;
    for (int i = 0; i < NW; i++) d[i] = DW'($urandom_range(0, 255));
    k = 0; t = 0;
    prog_mode = 1'b1;
    while (k < NW && t < 600) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = d[k];
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) model_mem[k] = d[k];  // DONE restarts loading at address 0
      tick();
      t++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 10) begin
      tick();
      t++;
    end
    checks++;
    if (k != NW || done !== 1'b1) begin
      errors++; $display("FAIL b2b_done: got accepts=%0d done=%b expected %0d/1", k, done, NW);
    end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (mem[i] !== model_mem[i]) begin
        errors++; $display("FAIL b2b_ram[%0d]: got %h expected %h", i, mem[i], model_mem[i]);
      end
    end
    checks++;
    if (inv_bad !== 1'b0) begin
      errors++; $display("FAIL bus_contention: got bus_drive_en and ram_enable together, expected never");
    end
  endtask

  initial begin
    test_reset();
    test_load_full();
    test_dump_full();
    test_dump_stall();
    test_run_mode();
    test_reset_mid_load();
    test_dump_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
